dmem_arbiter: RTL

Two-port arbiter and sequencer placed in front of `data_memory`, the word-wide data SRAM. That memory has a synchronous full-word write and a combinational read. This block shares the memory between the core LSU (port 0) and a DMA/debug requester (port 1). It adds byte-masked stores through a two-cycle read-modify-write, bounds-checks addresses, and returns registered read data.

---
 rtl/dmem_arb_pkg.sv | 29 ++
 rtl/dmem_byte_merge.sv | 28 ++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter and its helpers.
//   DMEM_AW     : word-address width of the data SRAM.
//   BMASK_FULL  : store mask that writes all four byte lanes.
//   BMASK_NONE  : store mask that writes nothing (accepted as a no-op).
//   arbState_e  : arbiter sequencer state (ARB_IDLE, ARB_RMW).
//   dmemReq_t   : one requester's store/load request (we, addr, bmask, wdata).
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DMEM_AW = 16;

  localparam logic [3:0] BMASK_FULL = 4'hF;
  localparam logic [3:0] BMASK_NONE = 4'h0;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RMW  = 1'b1
  } arbState_e;

  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [3:0]         bmask;
    logic [31:0]        wdata;
  } dmemReq_t;

endpackage

// File: rtl/dmem_byte_merge.sv
// ---------------------------------------------------------------------------
// dmem_byte_merge
// Combinational byte-lane merge: each lane whose mask bit is set takes the
// new word's byte, every other lane keeps the old word's byte. Also used by
// the cache fill path.
//   oldWord_i [31:0] : word currently stored in memory
//   newWord_i [31:0] : store data, byte lanes aligned
//   mask_i    [3:0]  : bit k selects byte k from newWord_i
//   merged_o  [31:0] : merged word
// ---------------------------------------------------------------------------
module dmem_byte_merge (
  input  logic [31:0] oldWord_i,
  input  logic [31:0] newWord_i,
  input  logic [3:0]  mask_i,
  output logic [31:0] merged_o
);

  // Start from the old word and overwrite only the enabled lanes.
  always_comb begin
    merged_o = oldWord_i;
    for (int k = 0; k < 4; k++) begin
      if (mask_i[k]) begin
        merged_o[8*k +: 8] = newWord_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the word-wide data SRAM (synchronous write, combinational read)
// between the core LSU (port 0) and a DMA/debug requester (port 1). Adds
// byte-masked stores via a two-cycle read-modify-write, bounds-checks word
// addresses against DEPTH and returns registered load data.
//
// Configuration macro: DMEM_ARB_RR_EN
//   defined   : round-robin between the ports on conflict (1-bit pointer)
//   undefined : fixed priority, port 0 always wins
//
// Ports (N = 0, 1):
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_pN_valid/o_pN_ready: request handshake
//   i_pN_we              : 1 = store, 0 = load
//   i_pN_addr [AW]       : word address
//   i_pN_bmask [4]       : store byte enables
//   i_pN_wdata [32]      : store data
//   o_pN_rvalid          : one-cycle load response pulse
//   o_pN_rdata [32]      : load data
//   o_mem_addr/o_mem_wren/o_mem_wdata : to the SRAM
//   i_mem_rdata [32]     : combinational SRAM read data
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = DMEM_AW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_p0_valid,
  output logic          o_p0_ready,
  input  logic          i_p0_we,
  input  logic [AW-1:0] i_p0_addr,
  input  logic [3:0]    i_p0_bmask,
  input  logic [31:0]   i_p0_wdata,
  output logic          o_p0_rvalid,
  output logic [31:0]   o_p0_rdata,
  input  logic          i_p1_valid,
  output logic          o_p1_ready,
  input  logic          i_p1_we,
  input  logic [AW-1:0] i_p1_addr,
  input  logic [3:0]    i_p1_bmask,
  input  logic [31:0]   i_p1_wdata,
  output logic          o_p1_rvalid,
  output logic [31:0]   o_p1_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_wren,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata
);

  localparam logic [DMEM_AW-1:0] DepthA = DMEM_AW'(DEPTH);

  arbState_e     state_q;
  logic [AW-1:0] capAddr_q;
  logic [31:0]   merged_q;
  logic          rvalid0_q, rvalid1_q;
  logic [31:0]   rdata0_q, rdata1_q;

  dmemReq_t    req0, req1, reqSel;
  logic        grant1, isIdle, xfer, inRange, isFull, isNone;
  logic        fullWrite, startRmw, loadXfer;
  logic [31:0] loadData, mergedNow;

  assign req0 = '{we: i_p0_we, addr: DMEM_AW'(i_p0_addr), bmask: i_p0_bmask, wdata: i_p0_wdata};
  assign req1 = '{we: i_p1_we, addr: DMEM_AW'(i_p1_addr), bmask: i_p1_bmask, wdata: i_p1_wdata};

`ifdef DMEM_ARB_RR_EN
  // last_q remembers which port won the previous transfer; on a conflict
  // the other port wins. Reset value 1 makes port 0 win the first conflict.
  logic last_q;
  assign grant1 = i_p1_valid & (~i_p0_valid | ~last_q);
`else
  assign grant1 = i_p1_valid & ~i_p0_valid;
`endif

  assign reqSel = grant1 ? req1 : req0;
  assign isIdle = (state_q == ARB_IDLE);

  // Readies are gated by reset and by the RMW cycle.
  assign o_p0_ready = i_rst_n & isIdle & i_p0_valid & ~grant1;
  assign o_p1_ready = i_rst_n & isIdle & grant1;
  assign xfer       = o_p0_ready | o_p1_ready;

  assign inRange   = (reqSel.addr < DepthA);
  assign isFull    = (reqSel.bmask == BMASK_FULL);
  assign isNone    = (reqSel.bmask == BMASK_NONE);
  assign fullWrite = xfer & reqSel.we & inRange & isFull;
  assign startRmw  = xfer & reqSel.we & inRange & ~isFull & ~isNone;
  assign loadXfer  = xfer & ~reqSel.we;
  assign loadData  = inRange ? i_mem_rdata : 32'h0;

  dmem_byte_merge uMerge (
    .oldWord_i (i_mem_rdata),
    .newWord_i (reqSel.wdata),
    .mask_i    (reqSel.bmask),
    .merged_o  (mergedNow)
  );

  // During RMW the captured address and merged word own the memory port.
  assign o_mem_addr  = isIdle ? AW'(reqSel.addr) : capAddr_q;
  assign o_mem_wdata = isIdle ? reqSel.wdata : merged_q;
  assign o_mem_wren  = i_rst_n & (~isIdle | fullWrite);

  assign o_p0_rvalid = rvalid0_q;
  assign o_p1_rvalid = rvalid1_q;
  assign o_p0_rdata  = rdata0_q;
  assign o_p1_rdata  = rdata1_q;

  // Sequencer: a partial in-range store captures its merged word and spends
  // one extra cycle writing it. Load data is registered from the
  // combinational read in the transfer cycle, so a same-cycle write is not
  // yet visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ARB_IDLE;
      capAddr_q <= '0;
      merged_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= loadXfer & ~grant1;
      rvalid1_q <= loadXfer & grant1;
      if (loadXfer & ~grant1) rdata0_q <= loadData;
      if (loadXfer & grant1)  rdata1_q <= loadData;
      case (state_q)
        ARB_IDLE: begin
          if (startRmw) begin
            capAddr_q <= AW'(reqSel.addr);
            merged_q  <= mergedNow;
            state_q   <= ARB_RMW;
          end
        end
        ARB_RMW: state_q <= ARB_IDLE;
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_RR_EN
  // The pointer follows every transfer, including no-op and out-of-range ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= 1'b1;
    end else if (xfer) begin
      last_q <= grant1;
    end
  end
`endif

endmodule
